// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants
package uart_pkg;
  typedef enum logic [2:0] {LINE_WAIT, IDLE, START, DATA, STOP} rx_state_t;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d, s2_q, s2_d;
  // next values simply shift the input down the chain
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end
  // synchronizer flops
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, valid/ready output, framing and overrun flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(2);

  logic                      rx_s;
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      commit_q, commit_d;
  logic                      ferr_q, ferr_d;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // frame FSM: line settle, start validation, data shift and stop check
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    commit_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      LINE_WAIT: begin
        if (!rx_s) cnt_d = '0;
        else if (cnt_q == CNT_SETTLE) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          state_d = rx_s ? IDLE : DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          cnt_d          = '0;
          state_d        = (idx_q == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          commit_d = rx_s;
          ferr_d   = !rx_s;
          state_d  = rx_s ? IDLE : LINE_WAIT;
        end
      end
      default: state_d = LINE_WAIT;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // output register: commit loads a byte, accept clears valid, overrun when unread byte is replaced
  always_comb begin
    rx_data_d   = commit_q ? shift_q : rx_data_q;
    rx_valid_d  = commit_q | (rx_valid_q & ~rx_ready);
    overrun_d   = commit_q & rx_valid_q & ~rx_ready;
    frame_err_d = ferr_q;
  end

  // all state, reset abandons any frame and pending byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LINE_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      commit_q    <= 1'b0;
      ferr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      commit_q    <= commit_d;
      ferr_q      <= ferr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a timed scoreboard of expected commits and errors
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int LAT = 4 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int checks = 0, failures = 0, cyc = 0, e = 0, fe_e = 0;
  int ev_kind[int];
  logic [7:0] ev_data[int];
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       exp_ovr, exp_fe;
  int rise_cnt = 0, rise_cyc = 0, fe_cnt = 0, fe_cyc = 0, ovr_cnt = 0, hi_cnt = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ideal transmitter; starts on a negedge, returns on the negedge where the next frame may begin
  task automatic send(input logic [7:0] d, input logic stop_b, input bit pop);
    rx = 1'b0;
    e = cyc + 1;
    if (stop_b) begin
      ev_kind[e + LAT] = 1;
      ev_data[e + LAT] = d;
    end else ev_kind[e + LAT] = 2;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_b;
    for (int i = 0; i < CPB; i++) begin
      if (pop) rx_ready = (i == 14);
      @(negedge clk);
    end
    if (pop) rx_ready = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else if (ev_kind.exists(cyc) && ev_kind[cyc] == 1) begin
      exp_ovr = m_valid && !rx_ready;
      m_valid = 1'b1;
      m_data  = ev_data[cyc];
    end else begin
      exp_fe = ev_kind.exists(cyc);
      if (m_valid && rx_ready) m_valid = 1'b0;
    end
    chk("rx_valid", 32'(rx_valid), 32'(m_valid));
    chk("rx_data", 32'(rx_data), 32'(m_data));
    chk("frame_err", 32'(frame_err), 32'(exp_fe));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = rx_data;
    end
    if (rx_valid) hi_cnt++;
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (overrun) ovr_cnt++;
    prev_valid = rx_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("linelow_rise", rise_cnt, 0);
    chk("linelow_fe", fe_cnt, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);

    rx_ready = 1'b1;
    hi_cnt = 0;
    send(8'hA5, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("single_lat", rise_cyc - e, 156);
    chk("single_data", 32'(rise_data), 32'hA5);
    chk("single_hi", hi_cnt, 1);

    rx_ready = 1'b0;
    rise_cnt = 0;
    ovr_cnt = 0;
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("b2b_rises", rise_cnt, 3);
    chk("b2b_ovr", ovr_cnt, 0);
    chk("b2b_last", 32'(rx_data), 32'h55);
    chk("b2b_valid", 32'(rx_valid), 32'h0);

    ovr_cnt = 0;
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovr_cnt", ovr_cnt, 1);
    chk("ovr_data", 32'(rx_data), 32'h34);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("ovr_accept", 32'(rx_valid), 32'h0);

    fe_cnt = 0;
    rise_cnt = 0;
    send(8'h3C, 1'b0, 1'b0);
    fe_e = e;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("fe_cnt", fe_cnt, 1);
    chk("fe_lat", fe_cyc - fe_e, 156);
    chk("fe_rise", rise_cnt, 0);
    rx_ready = 1'b1;
    send(8'h3C, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("fe_next_rise", rise_cnt, 1);
    chk("fe_next_data", 32'(rise_data), 32'h3C);

    rise_cnt = 0;
    fe_cnt = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_rise", rise_cnt, 0);
    chk("glitch_fe", fe_cnt, 0);
    send(8'h7E, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("glitch_next_rise", rise_cnt, 1);
    chk("glitch_next_data", 32'(rise_data), 32'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 8N1, mid-bit sampling, for the serial line driven by the CPU's `tx` pin. It recovers bytes into a valid/ready output register and flags framing errors and overruns. The same block serves two roles: as the CPU's `rx` front end, and as the bench-side monitor that captures CPU console output during `riscv_test` runs.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Legal range is 4..65535, even values only.
- `HALF`, default `CLKS_PER_BIT/2`: derived localparam. Not overridable.

**Ports**
- `clk`, input, 1: single clock; everything is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous serial line; idles high.
- `rx_data`, output, 8: received byte; valid while `rx_valid` is high.
- `rx_valid`, output, 1: byte available; held until accepted.
- `rx_ready`, input, 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err`, output, 1: one-cycle pulse; the stop bit was sampled low.
- `overrun`, output, 1: one-cycle pulse; a new byte arrived while the previous byte was not yet accepted.

## Operation

- **Synchronizer.** `rx` passes through a 2-FF synchronizer giving `rx_s`. Both FFs reset to 1.
- **LINE_WAIT** (reset state). Stay until `rx_s==1`, then go to IDLE. A line held low at reset never produces a spurious start.
- **IDLE.** When `rx_s==0`: clear the counter and go to START.
- **START.** Count HALF cycles, then resample `rx_s`:
  - 0: go to DATA with bit index 0.
  - 1: treat as a glitch; go back to IDLE with nothing reported.
- **DATA.** Every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit [idx], LSB first. After bit 7, go to STOP.
- **STOP.** After `CLKS_PER_BIT` cycles, sample `rx_s`:
  - 1: commit the byte, then go to IDLE.
  - 0: pulse `frame_err`, discard the byte, then go to LINE_WAIT. This is break handling: no re-arm until the line returns high.
- **Commit:**
  - `rx_data` is loaded with the shift register and `rx_valid` is set.
  - If `rx_valid` was already 1 and `rx_ready` is 0 in the commit cycle, also pulse `overrun`. The new byte overwrites the old one.
- **Accept:** `rx_valid && rx_ready` with no commit in the same cycle clears `rx_valid` next cycle.
- **Simultaneous accept and commit:** the new byte is loaded, `rx_valid` stays 1, and there is no `overrun`.
- **Counter:** `$clog2(CLKS_PER_BIT)` bits, zeroed on every state change, with no wrap inside a bit period. The bit index is 3 bits and never exceeds 7.

## Timing

- **Reset values:** `rx_data=0`, `rx_valid=0`, `frame_err=0`, `overrun=0`; state LINE_WAIT; sync FFs at 1.
- **Reset mid-frame** abandons the frame. Any pending byte is dropped and no pulse is emitted.
- **Start detection:** the first edge sampling `rx=0` is edge E. `rx_s` goes low at E+2, and START is entered at E+3.
- **Start sample** at E+3+HALF. Data bit *k* is sampled at E+3+HALF+(k+1)·`CLKS_PER_BIT`. The stop sample is at E+3+HALF+9·`CLKS_PER_BIT`.
- **Commit outputs** (`rx_valid` rising, `frame_err` pulse, `overrun` pulse) are registered and appear 1 cycle after the stop sample.
- **Total latency:** `rx_valid` rises at E+4+HALF+9·`CLKS_PER_BIT` (E+156 at `CLKS_PER_BIT=16`).
- **Back-to-back frames:** after STOP→IDLE, a start edge is detected immediately, so there are no dead cycles beyond the synchronizer.
- **Tolerated baud mismatch:** ±4% cumulative to the stop-bit sample.

## Structure

- **Package `uart_pkg`:**
  - `typedef enum logic [2:0] {LINE_WAIT, IDLE, START, DATA, STOP} rx_state_t`
  - `localparam int UART_DATA_BITS = 8`
  - A shared `uart_tx`, built next, reuses the same package.
- **Sub-module `sync_2ff`:** parameterised reset value, instantiated once for `rx`.
- **FSM, counter, shift register and output register** live in `uart_rx`.

## Test plan

All scenarios use `CLKS_PER_BIT=16`, with an ideal bench transmitter driving `rx` at 16 clocks per bit.

- **Reset with line low:** `rst` for 2 cycles with `rx=0`, then `rx` held 0 for 400 cycles. Require `rx_valid=0` and `frame_err=0` throughout, with the FSM staying in LINE_WAIT.
- **Single byte:** send 0xA5 with `rx_ready=1`. Require `rx_data=0xA5` and `rx_valid` high for exactly 1 cycle at E+156.
- **Back-to-back:** send 0x00, 0xFF, 0x55 consecutively, with `rx_ready` tied 0 and one pop per byte. Require three commits in order with no `overrun`.
- **Overrun:** send 0x12 then 0x34 with `rx_ready=0`. Require one `overrun` pulse at the second commit, `rx_data=0x34`, and `rx_valid` still 1. A ready pulse must then clear `rx_valid`.
- **Framing error / break:** send 0x3C with the stop bit 0, then hold `rx=0` for 100 cycles, then release. Require a `frame_err` pulse at E+156, no `rx_valid`, and a subsequent 0x3C received correctly.
- **Glitch:** drive a low pulse of 4 cycles on an idle line. Require no `rx_valid` and no `frame_err`; a following valid byte 0x7E must be received.
